inst_rom_loader: RTL and testbench

- Instruction-memory responder at the far end of the CPU fetch port. It receives chip-enable and byte address, and returns the 32-bit instruction in the same cycle; if_id registers the returned word.
- Adds a word-wide program-load port with a valid/ready handshake, driven by a small FSM. Testbenches and the boot path fill memory through this port before releasing the CPU.
- Sits beside the CPU top as the instruction-side memory.

---
 rtl/inst_rom_loader.sv | 142 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with same-cycle fetch and handshake program-load port
module inst_rom_loader #(
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rom_ce,
  input  logic [ADDR_W-1:0]     i_rom_addr,
  output logic [DATA_W-1:0]     o_rom_data,
  output logic                  o_fetch_err,
  input  logic                  i_ld_start,
  input  logic [DEPTH_LOG2-1:0] i_ld_base,
  input  logic [DEPTH_LOG2:0]   i_ld_count,
  input  logic                  i_ld_valid,
  input  logic [DATA_W-1:0]     i_ld_data,
  output logic                  o_ld_ready,
  output logic                  o_ld_done,
  output logic                  o_ld_err,
  output logic                  o_busy
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2+1:0] MEM_WORDS = (DEPTH_LOG2+2)'(1) << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_W-1:0]     mem [0:WORDS-1];
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2:0]   remaining;
  logic                  zero_done_q;
  logic                  err_q;
  logic                  fetch_err_q;

  logic                  ld_ready, busy, ld_done_st, wr_en;
  logic                  start_acc, start_zero, start_bad, start_go;
  logic [DEPTH_LOG2+1:0] ld_end;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  misaligned, oor, fetch_bad;

  assign idx        = i_rom_addr[DEPTH_LOG2+1:2];
  assign misaligned = |i_rom_addr[1:0];
  assign oor        = |i_rom_addr[ADDR_W-1:DEPTH_LOG2+2];
  assign fetch_bad  = i_rom_ce && !busy && (misaligned || oor);
  assign ld_end     = {2'b00, i_ld_base} + {1'b0, i_ld_count};

  // Next-state and handshake decode; outputs depend on state and the start request only
  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    ld_done_st = 1'b0;
    wr_en      = 1'b0;
    start_acc  = 1'b0;
    start_zero = 1'b0;
    start_bad  = 1'b0;
    start_go   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_ld_start) begin
          start_acc = 1'b1;
          if (i_ld_count == '0) begin
            start_zero = 1'b1;
          end else if (ld_end > MEM_WORDS) begin
            start_bad = 1'b1;
          end else begin
            start_go  = 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (i_ld_valid) begin
          wr_en = 1'b1;
          if (remaining == (DEPTH_LOG2+1)'(1)) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        ld_done_st = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Load pointer, word countdown, response pulses and the sticky fetch-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      remaining   <= '0;
      zero_done_q <= 1'b0;
      err_q       <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      zero_done_q <= start_zero;
      err_q       <= start_bad;
      if (start_go) begin
        ptr       <= i_ld_base;
        remaining <= i_ld_count;
      end else if (wr_en) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (fetch_bad)      fetch_err_q <= 1'b1;
      else if (start_acc) fetch_err_q <= 1'b0;
    end
  end

  // Memory write port; contents are deliberately not reset, and a reset cycle writes nothing
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[ptr] <= i_ld_data;
  end

  // Same-cycle fetch; blocked while loading so read and write never collide
  always_comb begin
    o_rom_data = '0;
    if (i_rom_ce && !busy && !misaligned && !oor) o_rom_data = mem[idx];
  end

  assign o_ld_ready  = ld_ready;
  assign o_busy      = busy;
  assign o_ld_done   = ld_done_st | zero_done_q;
  assign o_ld_err    = err_q;
  assign o_fetch_err = fetch_err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - self-checking bench for inst_rom_loader
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rom_ce;
  logic [31:0] i_rom_addr;
  logic [31:0] o_rom_data;
  logic        o_fetch_err;
  logic        i_ld_start;
  logic [9:0]  i_ld_base;
  logic [10:0] i_ld_count;
  logic        i_ld_valid;
  logic [31:0] i_ld_data;
  logic        o_ld_ready;
  logic        o_ld_done;
  logic        o_ld_err;
  logic        o_busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  inst_rom_loader #(.DEPTH_LOG2(10), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_rom_ce(i_rom_ce), .i_rom_addr(i_rom_addr), .o_rom_data(o_rom_data),
    .o_fetch_err(o_fetch_err),
    .i_ld_start(i_ld_start), .i_ld_base(i_ld_base), .i_ld_count(i_ld_count),
    .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .o_ld_ready(o_ld_ready), .o_ld_done(o_ld_done), .o_ld_err(o_ld_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_ferr;
  } fetch_vec_t;

  fetch_vec_t fv [10];
  logic [31:0] w  [4];
  logic [31:0] bp [3];
  logic [31:0] hi [4];
  logic [31:0] nw [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    i_rom_ce   = 1'b1;
    i_rom_addr = addr;
    #1;
    check(name, o_rom_data, exp);
    i_rom_ce   = 1'b0;
    i_rom_addr = '0;
  endtask

  task automatic start_load(input logic [9:0] base, input logic [10:0] cnt);
    i_ld_start = 1'b1;
    i_ld_base  = base;
    i_ld_count = cnt;
    tick();
    i_ld_start = 1'b0;
  endtask

  initial begin
    int rdy_cycles;
    int xfers;
    logic [5:0] vpat;

    w[0] = 32'h3c010001; w[1] = 32'h34210101; w[2] = 32'h00000000; w[3] = 32'h0000000c;
    bp[0] = 32'hb0b00008; bp[1] = 32'hb0b00009; bp[2] = 32'hb0b0000a;
    hi[0] = 32'h11110ff0; hi[1] = 32'h22220ff4; hi[2] = 32'h33330ff8; hi[3] = 32'h44440ffc;
    for (int i = 0; i < 6; i++) nw[i] = 32'hc0de0000 + 32'(i);

    fv[0] = '{1'b1, 32'h0000_0000, 32'h3c010001, 1'b0};
    fv[1] = '{1'b1, 32'h0000_0004, 32'h34210101, 1'b0};
    fv[2] = '{1'b1, 32'h0000_0008, 32'h00000000, 1'b0};
    fv[3] = '{1'b1, 32'h0000_000c, 32'h0000000c, 1'b0};
    fv[4] = '{1'b0, 32'h0000_0002, 32'h00000000, 1'b0};
    fv[5] = '{1'b0, 32'h0000_1000, 32'h00000000, 1'b0};
    fv[6] = '{1'b1, 32'h0000_0002, 32'h00000000, 1'b1};
    fv[7] = '{1'b1, 32'h0000_0004, 32'h34210101, 1'b1};
    fv[8] = '{1'b1, 32'h0000_1000, 32'h00000000, 1'b1};
    fv[9] = '{1'b0, 32'h0000_0000, 32'h00000000, 1'b1};

    rst = 1'b1; i_rom_ce = 1'b0; i_rom_addr = '0;
    i_ld_start = 1'b0; i_ld_base = '0; i_ld_count = '0; i_ld_valid = 1'b0; i_ld_data = '0;
    tick(); tick();
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_ready", 32'(o_ld_ready), 32'd0);
    check("reset_done", 32'(o_ld_done), 32'd0);
    check("reset_err", 32'(o_ld_err), 32'd0);
    check("reset_fetch_err", 32'(o_fetch_err), 32'd0);
    rst = 1'b0;
    tick();

    // Load 4 words at base 0, back-to-back
    start_load(10'd0, 11'd4);
    rdy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = w[i];
      if (o_ld_ready) rdy_cycles++;
      check("load4_busy", 32'(o_busy), 32'd1);
      tick();
    end
    i_ld_valid = 1'b0;
    check("load4_ready_cycles", 32'(rdy_cycles), 32'd4);
    check("load4_done", 32'(o_ld_done), 32'd1);
    check("load4_ready_off", 32'(o_ld_ready), 32'd0);
    tick();
    check("load4_done_once", 32'(o_ld_done), 32'd0);
    check("load4_idle", 32'(o_busy), 32'd0);

    // Fetch table: good words, ce=0 with bad address, then sticky errors
    for (int i = 0; i < 10; i++) begin
      i_rom_ce   = fv[i].ce;
      i_rom_addr = fv[i].addr;
      #1;
      check($sformatf("fetch%0d_data", i), o_rom_data, fv[i].exp_data);
      tick();
      check($sformatf("fetch%0d_ferr", i), 32'(o_fetch_err), 32'(fv[i].exp_ferr));
    end
    i_rom_ce = 1'b0; i_rom_addr = '0;

    // Backpressured load at base 8; accepted start clears the fetch error
    start_load(10'd8, 11'd3);
    check("bp_start_clears_ferr", 32'(o_fetch_err), 32'd0);
    vpat = 6'b101001;
    xfers = 0;
    rdy_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      i_ld_valid = vpat[c];
      i_ld_data  = vpat[c] ? bp[xfers] : 32'hdeadbeef;
      if (vpat[c]) xfers++;
      if (o_ld_ready) rdy_cycles++;
      i_rom_ce   = 1'b1;
      i_rom_addr = (c == 1) ? 32'h2 : 32'h0;
      #1;
      if (c == 0) check("busy_fetch_nop", o_rom_data, 32'h0);
      tick();
      i_rom_ce = 1'b0;
    end
    i_ld_valid = 1'b0;
    check("bp_ready_cycles", 32'(rdy_cycles), 32'd6);
    check("bp_done", 32'(o_ld_done), 32'd1);
    check("busy_fetch_no_ferr", 32'(o_fetch_err), 32'd0);
    tick();
    check("bp_done_once", 32'(o_ld_done), 32'd0);
    fetch_check("bp_w8", 32'h20, bp[0]);
    fetch_check("bp_w9", 32'h24, bp[1]);
    fetch_check("bp_w10", 32'h28, bp[2]);
    fetch_check("after_done_w0", 32'h0, w[0]);

    // count == 0: immediate done, never busy
    start_load(10'd5, 11'd0);
    check("zero_done", 32'(o_ld_done), 32'd1);
    check("zero_busy", 32'(o_busy), 32'd0);
    tick();
    check("zero_done_once", 32'(o_ld_done), 32'd0);
    check("zero_busy2", 32'(o_busy), 32'd0);

    // base=1020, count=4 fills up to the last word
    start_load(10'd1020, 11'd4);
    check("edge_accept_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = hi[i];
      tick();
    end
    i_ld_valid = 1'b0;
    check("edge_done", 32'(o_ld_done), 32'd1);
    tick();
    fetch_check("edge_w1023", 32'hffc, hi[3]);

    // base=1020, count=5 rejected; word 1020 untouched
    start_load(10'd1020, 11'd5);
    i_ld_valid = 1'b1;
    i_ld_data  = 32'hbad0bad0;
    check("range_err", 32'(o_ld_err), 32'd1);
    check("range_busy", 32'(o_busy), 32'd0);
    check("range_ready", 32'(o_ld_ready), 32'd0);
    tick();
    i_ld_valid = 1'b0;
    check("range_err_once", 32'(o_ld_err), 32'd0);
    fetch_check("range_w1020", 32'hff0, hi[0]);

    // Prefill words 4..5 with known old data, then reset in the middle of a 6-word load
    start_load(10'd4, 11'd2);
    for (int i = 0; i < 2; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = 32'h01d00004 + 32'(i);
      tick();
    end
    i_ld_valid = 1'b0;
    tick();
    start_load(10'd0, 11'd6);
    for (int i = 0; i < 3; i++) begin
      i_ld_valid = 1'b1;
      i_ld_data  = nw[i];
      tick();
    end
    i_ld_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_ld_ready), 32'd0);
    check("rst_no_done", 32'(o_ld_done), 32'd0);
    tick();
    check("rst_no_done2", 32'(o_ld_done), 32'd0);
    fetch_check("rst_w0", 32'h00, nw[0]);
    fetch_check("rst_w1", 32'h04, nw[1]);
    fetch_check("rst_w2", 32'h08, nw[2]);
    fetch_check("rst_w3", 32'h0c, w[3]);
    fetch_check("rst_w4", 32'h10, 32'h01d00004);
    fetch_check("rst_w5", 32'h14, 32'h01d00005);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
